// File: rtl/smooth_ctrl_pkg.sv
// smooth_ctrl shared types and sizing helpers.
// Frame sequencer for the t/x/y smoothing lanes.
package smooth_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

  // bits needed to hold values 0..v-1
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/smooth_ctrl_raster.sv
// Raster coordinate generator for the output stream.
// Holds the coordinate of the next pixel to be emitted.
module raster_counter #(
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 768
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            step,
  output logic [$clog2(FRAME_WIDTH)-1:0]  x,
  output logic [$clog2(FRAME_HEIGHT)-1:0] y,
  output logic                            last_col,
  output logic                            last_pix
);

  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  assign last_col = (x == XW'(FRAME_WIDTH - 1));
  assign last_pix = last_col && (y == YW'(FRAME_HEIGHT - 1));

  // advance x then y in raster order, wrapping at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (last_col) begin
        x <= '0;
        y <= last_pix ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/smooth_ctrl.sv
// Frame sequencer: input handshake, pipe enable,
// fill suppression, end-of-frame flush, output markers.
module smooth_ctrl
  import smooth_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 768,
  parameter int PIPE_LATENCY = 2053
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_sof,
  output logic                            in_ready,
  output logic                            pipe_en,
  output logic                            pipe_zero,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FRAME_WIDTH)-1:0]  out_x,
  output logic [$clog2(FRAME_HEIGHT)-1:0] out_y,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            out_eof,
  output logic                            frame_done,
  output logic                            err_sof,
  output logic                            busy
);

  localparam int N  = frame_pixels(FRAME_WIDTH, FRAME_HEIGHT);
  localparam int EW = cnt_width(N + PIPE_LATENCY);
  localparam int CW = cnt_width(N + 1);
  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  state_t        state, state_nx;
  logic [EW-1:0] e;
  logic [CW-1:0] in_cnt;
  logic          stall, last_acc, done, step;
  logic [XW-1:0] rc_x;
  logic [YW-1:0] rc_y;
  logic          rc_last_col, rc_last_pix;

  assign stall    = out_valid & ~out_ready;
  assign last_acc = (state == RUN) & pipe_en
                  & (in_cnt == CW'(N - 1));
  assign done     = (state == FLUSH) & out_valid
                  & out_ready & out_eof;
  // enables past the fill window produce a real pixel
  assign step     = pipe_en & (e >= EW'(PIPE_LATENCY - 1));
  assign busy     = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pipe_en) state_nx = (N == 1) ? FLUSH : RUN;
      RUN:     if (last_acc) state_nx = FLUSH;
      FLUSH:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake and enable decode; never advance while output stalled
  always_comb begin
    in_ready  = 1'b0;
    pipe_en   = 1'b0;
    pipe_zero = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        pipe_en  = in_valid & in_sof & ~stall;
      end
      RUN: begin
        in_ready = ~stall;
        pipe_en  = in_valid & ~stall;
      end
      FLUSH: begin
        pipe_zero = 1'b1;
        pipe_en   = (e < EW'(N + PIPE_LATENCY - 1)) & ~stall;
      end
      default: ;
    endcase
  end

  // per-frame enable and input counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e      <= '0;
      in_cnt <= '0;
    end else if (done) begin
      e      <= '0;
      in_cnt <= '0;
    end else if (pipe_en) begin
      e <= e + 1'b1;
      if (state != FLUSH) in_cnt <= in_cnt + 1'b1;
    end
  end

  raster_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (done),
    .step    (step),
    .x       (rc_x),
    .y       (rc_y),
    .last_col(rc_last_col),
    .last_pix(rc_last_pix)
  );

  // output valid and coordinate/marker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (step) begin
      out_valid <= 1'b1;
      out_x     <= rc_x;
      out_y     <= rc_y;
      out_sof   <= (rc_x == '0) && (rc_y == '0);
      out_eol   <= rc_last_col;
      out_eof   <= rc_last_pix;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= done;
      err_sof    <= (state == RUN) & pipe_en & in_sof;
    end
  end

endmodule

// File: tb/tb_smooth_ctrl.sv
// Directed bench for smooth_ctrl, 4x3 frame,
// latency 5, with hand-computed expectations.
module tb_smooth_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready;
  logic       pipe_en;
  logic       pipe_zero;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_x;
  logic [1:0] out_y;
  logic       out_sof, out_eol, out_eof;
  logic       frame_done, err_sof, busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int ready_mode = 0;
  int pat_i = 0;

  int run_en = 0, flush_en = 0;
  int rise_en = 0, rise_cyc = 0;
  int eof_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  int stall_seen = 0, stall_viol = 0;
  bit prev_valid = 1'b0;
  int q_x[$];
  int q_y[$];
  logic [2:0] q_f[$];

  smooth_ctrl #(
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(3),
    .PIPE_LATENCY(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .pipe_en   (pipe_en),
    .pipe_zero (pipe_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .frame_done(frame_done),
    .err_sof   (err_sof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    pat_i = pat_i + 1;
    out_ready = (ready_mode == 0) ? 1'b1 : (pat_i % 3 == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) begin
        stall_seen = stall_seen + 1;
        if (pipe_en || in_ready) stall_viol = stall_viol + 1;
      end
      if (out_valid && !prev_valid) begin
        rise_en  = run_en + flush_en;
        rise_cyc = cyc;
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        q_x.push_back(int'(out_x));
        q_y.push_back(int'(out_y));
        q_f.push_back({out_sof, out_eol, out_eof});
        if (out_eof) eof_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (err_sof) err_cnt = err_cnt + 1;
      if (pipe_en) begin
        if (pipe_zero) flush_en = flush_en + 1;
        else           run_en   = run_en + 1;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input bit sof, output bit fd);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    fd = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    while (!ok && t < 200) begin
      @(negedge clk);
      fd = frame_done;
      if (in_ready) ok = 1'b1;
      else          t = t + 1;
    end
    if (!ok) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 500) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
      else            t = t + 1;
    end
    if (!ok) check({tag, "_done_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input int nf);
    int k;
    check({tag, "_nout"}, q_x.size() - base, 12 * nf);
    for (int i = 0; i < 12 * nf && base + i < q_x.size(); i++) begin
      k = i % 12;
      check({tag, "_x"}, q_x[base+i], k % 4);
      check({tag, "_y"}, q_y[base+i], k / 4);
      check({tag, "_sof"}, int'(q_f[base+i][2]), (k == 0) ? 1 : 0);
      check({tag, "_eol"}, int'(q_f[base+i][1]), (k % 4 == 3) ? 1 : 0);
      check({tag, "_eof"}, int'(q_f[base+i][0]), (k == 11) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_q, b_run, b_fl, b_done, b_err, b_sv, b_ss;
    bit fd;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_pipe_en", int'(pipe_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_err", int'(err_sof), 0);
    check("rst_xy", int'({out_x, out_y}), 0);
    check("rst_flags", int'({out_sof, out_eol, out_eof}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // full rate frame
    b_q = q_x.size(); b_run = run_en; b_fl = flush_en;
    b_err = err_cnt; b_sv = stall_viol;
    for (int i = 0; i < 12; i++) push(i == 0, fd);
    wait_done("a");
    check("a_run_en", run_en - b_run, 12);
    check("a_flush_en", flush_en - b_fl, 4);
    check("a_first_valid_en", rise_en - b_run - b_fl, 5);
    check("a_full_rate", eof_cyc - rise_cyc, 11);
    check("a_done_lat", done_cyc - eof_cyc, 1);
    check("a_busy", int'(busy), 0);
    check("a_err", err_cnt - b_err, 0);
    check("a_stall_viol", stall_viol - b_sv, 0);
    check_frame("a", b_q, 1);

    // backpressure 1,0,0 pattern
    ready_mode = 1;
    b_q = q_x.size(); b_run = run_en; b_fl = flush_en;
    b_sv = stall_viol; b_ss = stall_seen;
    for (int i = 0; i < 12; i++) push(i == 0, fd);
    wait_done("b");
    ready_mode = 0;
    @(posedge clk);
    #1;
    check("b_run_en", run_en - b_run, 12);
    check("b_flush_en", flush_en - b_fl, 4);
    check("b_stalled", int'(stall_seen - b_ss > 0), 1);
    check("b_stall_viol", stall_viol - b_sv, 0);
    check_frame("b", b_q, 1);

    // leading non-sof pixels are dropped
    b_q = q_x.size(); b_run = run_en; b_fl = flush_en;
    for (int i = 0; i < 3; i++) push(1'b0, fd);
    check("c_pre_en", run_en - b_run, 0);
    check("c_pre_busy", int'(busy), 0);
    for (int i = 0; i < 12; i++) push(i == 0, fd);
    wait_done("c");
    check("c_run_en", run_en - b_run, 12);
    check("c_flush_en", flush_en - b_fl, 4);
    check_frame("c", b_q, 1);

    // sof mid-frame
    b_q = q_x.size(); b_err = err_cnt;
    for (int i = 0; i < 12; i++) push(i == 0 || i == 5, fd);
    wait_done("d");
    check("d_err_pulses", err_cnt - b_err, 1);
    check_frame("d", b_q, 1);

    // reset after 7 pixels
    for (int i = 0; i < 7; i++) push(i == 0, fd);
    rst = 1'b1;
    @(negedge clk);
    check("e_in_ready", int'(in_ready), 1);
    check("e_out_valid", int'(out_valid), 0);
    check("e_busy", int'(busy), 0);
    check("e_xy", int'({out_x, out_y}), 0);
    check("e_flags", int'({out_sof, out_eol, out_eof}), 0);
    check("e_pulses", int'({frame_done, err_sof}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_q = q_x.size(); b_run = run_en; b_fl = flush_en;
    for (int i = 0; i < 12; i++) push(i == 0, fd);
    wait_done("e");
    check("e_run_en", run_en - b_run, 12);
    check("e_flush_en", flush_en - b_fl, 4);
    check_frame("e", b_q, 1);

    // back-to-back frames
    b_q = q_x.size(); b_run = run_en; b_fl = flush_en;
    b_done = done_cnt;
    for (int i = 0; i < 12; i++) push(i == 0, fd);
    push(1'b1, fd);
    check("f_b2b_accept_on_done", int'(fd), 1);
    for (int i = 0; i < 11; i++) push(1'b0, fd);
    wait_done("f");
    check("f_done_cnt", done_cnt - b_done, 2);
    check("f_run_en", run_en - b_run, 24);
    check("f_flush_en", flush_en - b_fl, 8);
    check_frame("f", b_q, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
